// File: rtl/game_pkg.sv
// Shared game-flow definitions: state width and 3-bit state encodings.
// The display and audio blocks decode the same encodings.
package game_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] STATE_START    = 3'd0;
  localparam logic [STATE_W-1:0] STATE_LOAD     = 3'd1;
  localparam logic [STATE_W-1:0] STATE_PLAY     = 3'd2;
  localparam logic [STATE_W-1:0] STATE_HIT      = 3'd3;
  localparam logic [STATE_W-1:0] STATE_MISS     = 3'd4;
  localparam logic [STATE_W-1:0] STATE_PAUSE    = 3'd5;
  localparam logic [STATE_W-1:0] STATE_END_LOAD = 3'd6;
  localparam logic [STATE_W-1:0] STATE_GAME_END = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    ST_START    = STATE_START,
    ST_LOAD     = STATE_LOAD,
    ST_PLAY     = STATE_PLAY,
    ST_HIT      = STATE_HIT,
    ST_MISS     = STATE_MISS,
    ST_PAUSE    = STATE_PAUSE,
    ST_END_LOAD = STATE_END_LOAD,
    ST_GAME_END = STATE_GAME_END
  } game_state_t;

endpackage

// File: rtl/hit_encoder.sv
// Per-hole strobe encoder: population count plus lowest-index priority encode.
// Ports:
//   vec     - per-hole strobe vector
//   count_c - number of set bits (combinational)
//   idx_c   - index of lowest set bit, 0 when vec is empty (combinational)
module hit_encoder #(
  parameter int unsigned N_HOLES = 8
) (
  input  logic [N_HOLES-1:0]           vec,
  output logic [$clog2(N_HOLES+1)-1:0] count_c,
  output logic [$clog2(N_HOLES)-1:0]   idx_c
);

  localparam int unsigned CNT_W = $clog2(N_HOLES + 1);
  localparam int unsigned IDX_W = $clog2(N_HOLES);

  // Population count
  always_comb begin
    count_c = '0;
    for (int i = 0; i < int'(N_HOLES); i++) begin
      count_c = count_c + CNT_W'(vec[i]);
    end
  end

  // Scan high to low so the lowest set bit is written last and wins
  always_comb begin
    idx_c = '0;
    for (int i = int'(N_HOLES) - 1; i >= 0; i--) begin
      if (vec[i]) idx_c = IDX_W'(i);
    end
  end

endmodule

// File: rtl/game_ctrl_fsm.sv
// Whack-a-mole game-flow controller: phase FSM, round timer, hit/miss
// arbitration, saturating score and lives counters.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start_btn, pause_btn  - single-cycle button strobes
//   load_done             - loader/animation handshake
//   tick                  - round-timer enable strobe
//   hit, miss             - per-hole strobes
//   out_*                 - registered phase flags decoded from next state
//   event_hit, event_miss - one-cycle pulses on entering HIT / MISS
//   hole_idx              - lowest hole of the last accepted hit/miss vector
//   score, lives, time_left - game counters
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int unsigned N_HOLES    = 8,
  parameter int unsigned SCORE_W    = 10,
  parameter int unsigned TIME_W     = 8,
  parameter int unsigned GAME_TICKS = 60,
  parameter int unsigned MAX_LIVES  = 3,
  parameter int unsigned LIVES_EN   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_btn,
  input  logic                           pause_btn,
  input  logic                           load_done,
  input  logic                           tick,
  input  logic [N_HOLES-1:0]             hit,
  input  logic [N_HOLES-1:0]             miss,
  output logic                           out_start,
  output logic                           out_load,
  output logic                           out_game,
  output logic                           out_pause,
  output logic                           out_game_end,
  output logic                           event_hit,
  output logic                           event_miss,
  output logic [$clog2(N_HOLES)-1:0]     hole_idx,
  output logic [SCORE_W-1:0]             score,
  output logic [$clog2(MAX_LIVES+1)-1:0] lives,
  output logic [TIME_W-1:0]              time_left
);

  localparam int unsigned IDX_W   = $clog2(N_HOLES);
  localparam int unsigned CNT_W   = $clog2(N_HOLES + 1);
  localparam int unsigned LIVES_W = $clog2(MAX_LIVES + 1);
  localparam int unsigned SUM_W   = SCORE_W + 1;

  game_state_t        state_q, state_d;
  logic [SCORE_W-1:0] score_d;
  logic [LIVES_W-1:0] lives_d;
  logic [TIME_W-1:0]  time_d;
  logic [IDX_W-1:0]   hole_d;
  logic               ev_hit_d, ev_miss_d;

  logic [CNT_W-1:0]   hit_cnt, miss_cnt;
  logic [IDX_W-1:0]   hit_idx, miss_idx;
  logic [SUM_W-1:0]   score_sum;
  logic               timer_run;
  logic               game_over;

  hit_encoder #(.N_HOLES(N_HOLES)) u_hit_enc (
    .vec     (hit),
    .count_c (hit_cnt),
    .idx_c   (hit_idx)
  );

  hit_encoder #(.N_HOLES(N_HOLES)) u_miss_enc (
    .vec     (miss),
    .count_c (miss_cnt),
    .idx_c   (miss_idx)
  );

  assign score_sum = {1'b0, score} + SUM_W'(hit_cnt);
  assign timer_run = (state_q == ST_PLAY) || (state_q == ST_HIT) || (state_q == ST_MISS);
  assign game_over = (time_left == '0) || ((LIVES_EN != 0) && (lives == '0));

  // Next-state and next-counter logic
  always_comb begin
    state_d   = state_q;
    score_d   = score;
    lives_d   = lives;
    time_d    = time_left;
    hole_d    = hole_idx;
    ev_hit_d  = 1'b0;
    ev_miss_d = 1'b0;

    // Timer counts in every in-game state, independent of any transition
    if (timer_run && tick && (time_left != '0)) begin
      time_d = time_left - TIME_W'(1);
    end

    case (state_q)
      ST_START: begin
        if (start_btn) begin
          state_d = ST_LOAD;
          score_d = '0;
          lives_d = LIVES_W'(MAX_LIVES);
          time_d  = TIME_W'(GAME_TICKS);
        end
      end
      ST_LOAD: begin
        if (load_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (game_over) begin
          state_d = ST_END_LOAD;
        end else if (pause_btn) begin
          state_d = ST_PAUSE;
        end else if (hit_cnt != '0) begin
          // Hits take precedence; same-cycle misses are dropped
          state_d  = ST_HIT;
          ev_hit_d = 1'b1;
          hole_d   = hit_idx;
          score_d  = score_sum[SUM_W-1] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        end else if (miss_cnt != '0) begin
          state_d   = ST_MISS;
          ev_miss_d = 1'b1;
          hole_d    = miss_idx;
          if ((LIVES_EN != 0) && (lives != '0)) begin
            lives_d = lives - LIVES_W'(1);
          end
        end
      end
      ST_HIT, ST_MISS: begin
        if (load_done) state_d = ST_PLAY;
      end
      ST_PAUSE: begin
        if (pause_btn) state_d = ST_PLAY;
      end
      ST_END_LOAD: begin
        if (load_done) state_d = ST_GAME_END;
      end
      ST_GAME_END: begin
        if (start_btn) state_d = ST_START;
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  // State, counters and flags; flags decode next state so they never lag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_START;
      score        <= '0;
      lives        <= LIVES_W'(MAX_LIVES);
      time_left    <= TIME_W'(GAME_TICKS);
      hole_idx     <= '0;
      event_hit    <= 1'b0;
      event_miss   <= 1'b0;
      out_start    <= 1'b1;
      out_load     <= 1'b0;
      out_game     <= 1'b0;
      out_pause    <= 1'b0;
      out_game_end <= 1'b0;
    end else begin
      state_q      <= state_d;
      score        <= score_d;
      lives        <= lives_d;
      time_left    <= time_d;
      hole_idx     <= hole_d;
      event_hit    <= ev_hit_d;
      event_miss   <= ev_miss_d;
      out_start    <= (state_d == ST_START);
      out_load     <= (state_d == ST_LOAD) || (state_d == ST_END_LOAD);
      out_game     <= (state_d == ST_PLAY) || (state_d == ST_HIT) || (state_d == ST_MISS);
      out_pause    <= (state_d == ST_PAUSE);
      out_game_end <= (state_d == ST_GAME_END);
    end
  end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm (GAME_TICKS=5). A second instance with
// LIVES_EN=0 shares the stimulus for the lives-disabled checks.
module tb_game_ctrl_fsm;

  localparam logic [4:0] F_START = 5'b10000;
  localparam logic [4:0] F_LOAD  = 5'b01000;
  localparam logic [4:0] F_GAME  = 5'b00100;
  localparam logic [4:0] F_PAUSE = 5'b00010;
  localparam logic [4:0] F_END   = 5'b00001;

  typedef struct packed {
    logic       start_btn;
    logic       pause_btn;
    logic       load_done;
    logic       tick;
    logic [7:0] hit;
    logic [7:0] miss;
  } vin_t;

  typedef struct packed {
    logic [4:0] flags;
    logic       ev_hit;
    logic       ev_miss;
    logic [2:0] hole;
    logic [9:0] score;
    logic [1:0] lives;
    logic [7:0] time_left;
  } vout_t;

  typedef struct packed {
    vin_t  in;
    vout_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn, pause_btn, load_done, tick;
  logic [7:0] hit, miss;

  logic       out_start, out_load, out_game, out_pause, out_game_end;
  logic       event_hit, event_miss;
  logic [2:0] hole_idx;
  logic [9:0] score;
  logic [1:0] lives;
  logic [7:0] time_left;

  logic       out_start2, out_load2, out_game2, out_pause2, out_game_end2;
  logic       event_hit2, event_miss2;
  logic [2:0] hole_idx2;
  logic [9:0] score2;
  logic [1:0] lives2;
  logic [7:0] time_left2;

  int total = 0;
  int bad   = 0;

  vec_t vecs[36];
  int   nvec = 0;

  always #5 clk = ~clk;

  game_ctrl_fsm #(.GAME_TICKS(5)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
    .load_done(load_done), .tick(tick), .hit(hit), .miss(miss),
    .out_start(out_start), .out_load(out_load), .out_game(out_game),
    .out_pause(out_pause), .out_game_end(out_game_end),
    .event_hit(event_hit), .event_miss(event_miss), .hole_idx(hole_idx),
    .score(score), .lives(lives), .time_left(time_left)
  );

  game_ctrl_fsm #(.GAME_TICKS(5), .LIVES_EN(0)) dut2 (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
    .load_done(load_done), .tick(tick), .hit(hit), .miss(miss),
    .out_start(out_start2), .out_load(out_load2), .out_game(out_game2),
    .out_pause(out_pause2), .out_game_end(out_game_end2),
    .event_hit(event_hit2), .event_miss(event_miss2), .hole_idx(hole_idx2),
    .score(score2), .lives(lives2), .time_left(time_left2)
  );

  function automatic vin_t mi(logic s, logic p, logic l, logic t,
                              logic [7:0] h, logic [7:0] m);
    vin_t v;
    v.start_btn = s; v.pause_btn = p; v.load_done = l; v.tick = t;
    v.hit = h; v.miss = m;
    return v;
  endfunction

  function automatic vout_t mo(logic [4:0] f, logic eh, logic em, logic [2:0] hi,
                               logic [9:0] sc, logic [1:0] lv, logic [7:0] tl);
    vout_t o;
    o.flags = f; o.ev_hit = eh; o.ev_miss = em; o.hole = hi;
    o.score = sc; o.lives = lv; o.time_left = tl;
    return o;
  endfunction

  task automatic add(input vin_t i, input vout_t e);
    vecs[nvec].in  = i;
    vecs[nvec].exp = e;
    nvec++;
  endtask

  // Apply one input vector across one clock edge; outputs are settled on return
  task automatic drive(input vin_t v);
    @(negedge clk);
    start_btn = v.start_btn; pause_btn = v.pause_btn; load_done = v.load_done;
    tick = v.tick; hit = v.hit; miss = v.miss;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input vout_t e);
    vout_t a;
    a = mo({out_start, out_load, out_game, out_pause, out_game_end},
           event_hit, event_miss, hole_idx, score, lives, time_left);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got flags=%b evh=%b evm=%b hole=%0d score=%0d lives=%0d time=%0d, want flags=%b evh=%b evm=%b hole=%0d score=%0d lives=%0d time=%0d",
               name, a.flags, a.ev_hit, a.ev_miss, a.hole, a.score, a.lives, a.time_left,
               e.flags, e.ev_hit, e.ev_miss, e.hole, e.score, e.lives, e.time_left);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    vin_t  idle;
    vout_t rst_exp;
    idle    = mi(0, 0, 0, 0, 8'h00, 8'h00);
    rst_exp = mo(F_START, 0, 0, 3'd0, 10'd0, 2'd3, 8'd5);

    // Main flow: start, hits, hit+miss collision, lives run-out, timer expiry
    add(mi(1,0,0,0,8'h00,8'h00), mo(F_LOAD, 0,0,3'd0,10'd0,2'd3,8'd5));  // 0 start
    add(idle,                    mo(F_LOAD, 0,0,3'd0,10'd0,2'd3,8'd5));  // 1
    add(mi(0,0,1,0,8'h00,8'h00), mo(F_GAME, 0,0,3'd0,10'd0,2'd3,8'd5));  // 2 play
    add(mi(0,0,0,0,8'h24,8'h00), mo(F_GAME, 1,0,3'd2,10'd2,2'd3,8'd5));  // 3 two hits
    add(idle,                    mo(F_GAME, 0,0,3'd2,10'd2,2'd3,8'd5));  // 4 pulse ends
    add(mi(0,0,0,0,8'h01,8'h00), mo(F_GAME, 0,0,3'd2,10'd2,2'd3,8'd5));  // 5 hit ignored in HIT
    add(mi(0,0,1,0,8'h00,8'h00), mo(F_GAME, 0,0,3'd2,10'd2,2'd3,8'd5));  // 6 back to play
    add(mi(0,0,0,0,8'h01,8'h80), mo(F_GAME, 1,0,3'd0,10'd3,2'd3,8'd5));  // 7 hit beats miss
    add(mi(0,0,1,0,8'h00,8'h00), mo(F_GAME, 0,0,3'd0,10'd3,2'd3,8'd5));  // 8
    add(mi(0,0,0,0,8'h00,8'h10), mo(F_GAME, 0,1,3'd4,10'd3,2'd2,8'd5));  // 9 miss
    add(mi(0,0,1,0,8'h00,8'h00), mo(F_GAME, 0,0,3'd4,10'd3,2'd2,8'd5));  // 10
    add(mi(0,0,0,0,8'h00,8'h02), mo(F_GAME, 0,1,3'd1,10'd3,2'd1,8'd5));  // 11 miss
    add(mi(0,0,1,0,8'h00,8'h00), mo(F_GAME, 0,0,3'd1,10'd3,2'd1,8'd5));  // 12
    add(mi(0,0,0,0,8'h00,8'h80), mo(F_GAME, 0,1,3'd7,10'd3,2'd0,8'd5));  // 13 last life
    add(mi(0,0,1,0,8'h00,8'h00), mo(F_GAME, 0,0,3'd7,10'd3,2'd0,8'd5));  // 14
    add(mi(0,0,0,0,8'h01,8'h00), mo(F_LOAD, 0,0,3'd7,10'd3,2'd0,8'd5));  // 15 lives=0 -> END_LOAD
    add(mi(1,0,0,0,8'h00,8'h00), mo(F_LOAD, 0,0,3'd7,10'd3,2'd0,8'd5));  // 16 start ignored
    add(mi(0,0,1,0,8'h00,8'h00), mo(F_END,  0,0,3'd7,10'd3,2'd0,8'd5));  // 17 game end
    add(mi(0,1,0,0,8'h00,8'h00), mo(F_END,  0,0,3'd7,10'd3,2'd0,8'd5));  // 18 pause ignored
    add(mi(1,0,0,0,8'h00,8'h00), mo(F_START,0,0,3'd7,10'd3,2'd0,8'd5));  // 19 score held
    add(mi(1,0,0,0,8'h00,8'h00), mo(F_LOAD, 0,0,3'd7,10'd0,2'd3,8'd5));  // 20 new game
    add(mi(0,0,1,0,8'h00,8'h00), mo(F_GAME, 0,0,3'd7,10'd0,2'd3,8'd5));  // 21
    add(mi(0,0,0,1,8'h00,8'h00), mo(F_GAME, 0,0,3'd7,10'd0,2'd3,8'd4));  // 22 tick 1
    add(mi(0,1,0,1,8'h00,8'h00), mo(F_PAUSE,0,0,3'd7,10'd0,2'd3,8'd3));  // 23 tick 2 + pause
    add(mi(0,0,0,1,8'h00,8'h00), mo(F_PAUSE,0,0,3'd7,10'd0,2'd3,8'd3));  // 24 frozen
    add(mi(0,0,1,0,8'hFF,8'h00), mo(F_PAUSE,0,0,3'd7,10'd0,2'd3,8'd3));  // 25 ignored
    add(mi(0,1,0,1,8'h00,8'h00), mo(F_GAME, 0,0,3'd7,10'd0,2'd3,8'd3));  // 26 unpause, no count
    add(mi(0,0,0,1,8'h08,8'h00), mo(F_GAME, 1,0,3'd3,10'd1,2'd3,8'd2));  // 27 tick 3 + hit
    add(mi(0,0,0,1,8'h00,8'h00), mo(F_GAME, 0,0,3'd3,10'd1,2'd3,8'd1));  // 28 tick 4
    add(mi(0,0,0,1,8'h00,8'h00), mo(F_GAME, 0,0,3'd3,10'd1,2'd3,8'd0));  // 29 tick 5
    add(mi(0,0,0,1,8'h00,8'h00), mo(F_GAME, 0,0,3'd3,10'd1,2'd3,8'd0));  // 30 stops at 0
    add(mi(0,0,1,0,8'h00,8'h00), mo(F_GAME, 0,0,3'd3,10'd1,2'd3,8'd0));  // 31 back to play
    add(mi(0,0,0,0,8'h01,8'h00), mo(F_LOAD, 0,0,3'd3,10'd1,2'd3,8'd0));  // 32 expiry wins
    add(mi(0,0,1,0,8'h00,8'h00), mo(F_END,  0,0,3'd3,10'd1,2'd3,8'd0));  // 33
    add(mi(1,0,0,0,8'h00,8'h00), mo(F_START,0,0,3'd3,10'd1,2'd3,8'd0));  // 34
    add(mi(1,0,0,0,8'h00,8'h00), mo(F_LOAD, 0,0,3'd3,10'd0,2'd3,8'd5));  // 35 reload

    start_btn = 0; pause_btn = 0; load_done = 0; tick = 0; hit = '0; miss = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", rst_exp);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Score saturation: 127 full-board hits reach 1016, the next one clips
    drive(mi(0,0,1,0,8'h00,8'h00));
    for (int i = 0; i < 127; i++) begin
      drive(mi(0,0,0,0,8'hFF,8'h00));
      drive(mi(0,0,1,0,8'h00,8'h00));
    end
    check_val("score_1016", int'(score), 1016);
    drive(mi(0,0,0,0,8'hFF,8'h00));
    check("score_sat", mo(F_GAME,1,0,3'd0,10'd1023,2'd3,8'd5));
    drive(mi(0,0,1,0,8'h00,8'h00));
    drive(mi(0,0,0,0,8'h01,8'h00));
    check("score_hold_sat", mo(F_GAME,1,0,3'd0,10'd1023,2'd3,8'd5));

    // Reset while in HIT, with other inputs active
    @(negedge clk);
    reset = 1'b1; start_btn = 1; load_done = 1; hit = 8'hFF; tick = 1;
    @(posedge clk);
    #1;
    check("reset_in_hit", rst_exp);
    check_val("reset_in_hit_dut2_start", int'(out_start2), 1);
    @(negedge clk);
    reset = 1'b0; start_btn = 0; load_done = 0; hit = '0; tick = 0;

    // Lives: LIVES_EN=1 runs out, LIVES_EN=0 keeps playing
    drive(mi(1,0,0,0,8'h00,8'h00));
    drive(mi(0,0,1,0,8'h00,8'h00));
    for (int i = 0; i < 3; i++) begin
      drive(mi(0,0,0,0,8'h00,8'h01));
      check_val($sformatf("lives_en_miss%0d", i), int'(lives), 2 - i);
      check_val($sformatf("lives_dis_miss%0d", i), int'(lives2), 3);
      check_val($sformatf("lives_dis_event%0d", i), int'(event_miss2), 1);
      drive(mi(0,0,1,0,8'h00,8'h00));
    end
    drive(idle);
    check_val("lives_en_end_load", int'(out_load), 1);
    check_val("lives_dis_still_game", int'(out_game2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
